// File: rtl/alu_iter_exec_pkg.sv
// Shared definitions for the EX-stage ALU and the ALU control decoder.
// Holds the 4-bit ALU control codes, the execution FSM state encoding and
// the shift-direction encoding used by the iterative shifter.
package alu_iter_exec_pkg;

   // ALU control codes produced by ALU control decode
   localparam logic [3:0] AluAnd = 4'b0000;
   localparam logic [3:0] AluOr  = 4'b0001;
   localparam logic [3:0] AluAdd = 4'b0010;
   localparam logic [3:0] AluSub = 4'b0110;
   localparam logic [3:0] AluSlt = 4'b0111;
   localparam logic [3:0] AluSll = 4'b1000;
   localparam logic [3:0] AluSrl = 4'b1001;
   localparam logic [3:0] AluSra = 4'b1010;
   localparam logic [3:0] AluNor = 4'b1100;

   // Execution FSM states
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

   // Direction latched at accept for the iterative shifter
   typedef enum logic [1:0] {
      ShSll = 2'd0,
      ShSrl = 2'd1,
      ShSra = 2'd2
   } shift_e;

   // Map a shift control code to its direction; non-shift codes map to ShSll
   function automatic shift_e shift_dir(input logic [3:0] ctrl);
      shift_e dir;
      dir = ShSll;
      if (ctrl == AluSrl) dir = ShSrl;
      if (ctrl == AluSra) dir = ShSra;
      return dir;
   endfunction

endpackage

// File: rtl/alu_core_comb.sv
// Single-cycle combinational ALU core.
// Computes add, sub, and, or, slt (signed), nor and classifies the control code.
// Ports:
//   alu_ctrl  in   4-bit ALU control code
//   a, b      in   operands
//   result    out  single-cycle result (0 for shifts and illegal codes)
//   is_shift  out  code is sll/srl/sra (handled by the iterative shifter)
//   illegal   out  code is not one of the nine legal codes (X/Z included)
module alu_core_comb
   import alu_iter_exec_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             is_shift,
   output logic             illegal
);

   logic slt_bit;

   assign slt_bit = ($signed(a) < $signed(b));

   // Plain case: an X/Z code matches no item and falls into default (illegal)
   always_comb begin
      result   = '0;
      is_shift = 1'b0;
      illegal  = 1'b0;
      case (alu_ctrl)
         AluAdd: result = a + b;
         AluSub: result = a - b;
         AluAnd: result = a & b;
         AluOr:  result = a | b;
         AluSlt: result = {{(WIDTH-1){1'b0}}, slt_bit};
         AluNor: result = ~(a | b);
         AluSll, AluSrl, AluSra: is_shift = 1'b1;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_iter_exec.sv
// EX-stage execution unit: single-cycle logic/arithmetic ops plus an
// iterative shifter (one bit per cycle), behind a valid/ready handshake.
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  operation handshake; in_ready only in IDLE
//   alu_ctrl, a, b       control code and operands (b is the shift source)
//   shamt                shift amount
//   out_valid/out_ready  result handshake; out_valid only in DONE
//   result, zero         registered result and result==0 flag
//   illegal              alu_ctrl was not a legal code
//   busy                 unit in SHIFT or DONE; stalls the pipeline
module alu_iter_exec
   import alu_iter_exec_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         alu_ctrl,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               zero,
   output logic               illegal,
   output logic               busy
);

   localparam logic [SHAMT_W-1:0] CntOne = SHAMT_W'(1);

   state_e               state_q;
   shift_e               dir_q;
   logic [WIDTH-1:0]     sh_q;
   logic [WIDTH-1:0]     sh_next;
   logic [SHAMT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]     result_q;
   logic                 zero_q;
   logic                 illegal_q;

   logic [WIDTH-1:0]     core_result;
   logic                 core_is_shift;
   logic                 core_illegal;

   alu_core_comb #(
      .WIDTH (WIDTH)
   ) u_core (
      .alu_ctrl (alu_ctrl),
      .a        (a),
      .b        (b),
      .result   (core_result),
      .is_shift (core_is_shift),
      .illegal  (core_illegal)
   );

   // One-bit step of the shifter; sra replicates the MSB
   always_comb begin
      sh_next = sh_q;
      case (dir_q)
         ShSll:   sh_next = {sh_q[WIDTH-2:0], 1'b0};
         ShSrl:   sh_next = {1'b0, sh_q[WIDTH-1:1]};
         ShSra:   sh_next = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
         default: sh_next = sh_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         dir_q     <= ShSll;
         sh_q      <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid) begin
                  if (core_illegal) begin
                     result_q  <= '0;
                     zero_q    <= 1'b1;
                     illegal_q <= 1'b1;
                     state_q   <= StDone;
                  end else if (core_is_shift) begin
                     if (shamt == '0) begin
                        result_q <= b;
                        zero_q   <= (b == '0);
                        state_q  <= StDone;
                     end else begin
                        // result stays untouched until the final shift lands
                        sh_q    <= b;
                        cnt_q   <= shamt;
                        dir_q   <= shift_dir(alu_ctrl);
                        state_q <= StShift;
                     end
                  end else begin
                     result_q <= core_result;
                     zero_q   <= (core_result == '0);
                     state_q  <= StDone;
                  end
               end
            end
            StShift: begin
               sh_q  <= sh_next;
               cnt_q <= cnt_q - CntOne;
               if (cnt_q == CntOne) begin
                  result_q <= sh_next;
                  zero_q   <= (sh_next == '0);
                  state_q  <= StDone;
               end
            end
            StDone: begin
               if (out_ready) begin
                  illegal_q <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign out_valid = (state_q == StDone);
   assign result    = result_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_iter_exec.sv
// Self-checking bench for alu_iter_exec: directed plan cases plus randomized
// operations checked against a behavioural model of the ALU rules.
module tb_alu_iter_exec;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_ctrl;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  shamt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        illegal;
   logic        busy;

   int checks = 0;
   int errors = 0;

   alu_iter_exec #(
      .WIDTH   (32),
      .SHAMT_W (5)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctrl  (alu_ctrl),
      .a         (a),
      .b         (b),
      .shamt     (shamt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic ref_illegal(input logic [3:0] c);
      return !(c inside {4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111,
                         4'b1100, 4'b1000, 4'b1001, 4'b1010});
   endfunction

   function automatic logic [31:0] ref_result(input logic [3:0] c, input logic [31:0] x,
                                              input logic [31:0] y, input logic [4:0] s);
      logic signed [31:0] ys;
      ys = y;
      case (c)
         4'b0010: return x + y;
         4'b0110: return x - y;
         4'b0000: return x & y;
         4'b0001: return x | y;
         4'b0111: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'b1100: return ~(x | y);
         4'b1000: return y << s;
         4'b1001: return y >> s;
         4'b1010: return ys >>> s;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int ref_latency(input logic [3:0] c, input logic [4:0] s);
      if ((c == 4'b1000 || c == 4'b1001 || c == 4'b1010) && s != 0) return int'(s) + 1;
      return 1;
   endfunction

   // ---------------- drivers (no checking) ----------------
   // Called at a negedge with the unit idle; returns at the negedge where
   // out_valid is first seen. lat = cycles from accept edge, -1 on timeout.
   task automatic issue_op(input logic [3:0] c, input logic [31:0] av, input logic [31:0] bv,
                           input logic [4:0] s, output int lat);
      alu_ctrl = c;
      a        = av;
      b        = bv;
      shamt    = s;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      // scramble inputs: only values present at accept may matter
      alu_ctrl = 4'($urandom);
      a        = $urandom;
      b        = $urandom;
      shamt    = 5'($urandom);
      lat      = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic release_op();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd0 ||
          zero !== 1'b0 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: in_ready=%b out_valid=%b busy=%b result=%h zero=%b illegal=%b, need 1 0 0 0 0 0",
                  in_ready, out_valid, busy, result, zero, illegal);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [3:0]  cv [9];
      logic [31:0] av [9];
      logic [31:0] bv [9];
      logic [4:0]  sv [9];
      int          lat;
      logic [31:0] exp_r;
      cv = '{4'b0010, 4'b0110, 4'b0111, 4'b0111, 4'b1000, 4'b1010, 4'b0011, 4'b1001, 4'b1100};
      av = '{32'h5, 32'h1234, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 32'h77, 32'h0, 32'hF0F0F0F0};
      bv = '{32'h3, 32'h1234, 32'h1, 32'hFFFFFFFF, 32'h1, 32'h80000000, 32'h55,
             32'hA5A5A5A5, 32'h0F0F0F0E};
      sv = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd4, 5'd0, 5'd0, 5'd0};
      for (int i = 0; i < 9; i++) begin
         exp_r = ref_result(cv[i], av[i], bv[i], sv[i]);
         issue_op(cv[i], av[i], bv[i], sv[i], lat);
         checks++;
         if (lat != ref_latency(cv[i], sv[i])) begin
            errors++;
            $display("FAIL dir%0d_latency: got %0d need %0d", i, lat, ref_latency(cv[i], sv[i]));
         end
         checks++;
         if (result !== exp_r || zero !== (exp_r == 0) || illegal !== ref_illegal(cv[i]) ||
             busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL dir%0d_result: result=%h zero=%b illegal=%b busy=%b in_ready=%b need %h %b %b 1 0",
                     i, result, zero, illegal, busy, in_ready, exp_r, exp_r == 0,
                     ref_illegal(cv[i]));
         end
         release_op();
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || illegal !== 1'b0 ||
             result !== exp_r) begin
            errors++;
            $display("FAIL dir%0d_release: out_valid=%b in_ready=%b busy=%b illegal=%b result=%h need 0 1 0 0 %h",
                     i, out_valid, in_ready, busy, illegal, result, exp_r);
         end
      end
   endtask

   task automatic test_backpressure();
      int          lat;
      logic [31:0] exp_r;
      exp_r = ref_result(4'b0110, 32'd100, 32'd100, 5'd0);
      issue_op(4'b0110, 32'd100, 32'd100, 5'd0, lat);
      for (int i = 0; i < 5; i++) begin
         // offer a different op while stalled; it must be ignored
         alu_ctrl = 4'b0010;
         a        = $urandom;
         b        = 32'd1;
         in_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp_r || zero !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b result=%h zero=%b need 1 0 %h 1",
                     i, out_valid, in_ready, result, zero, exp_r);
         end
      end
      in_valid = 1'b0;
      release_op();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== exp_r) begin
         errors++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b result=%h need 0 1 %h",
                  out_valid, in_ready, result, exp_r);
      end
   endtask

   task automatic test_reset_mid_shift();
      int lat;
      alu_ctrl = 4'b1000;
      a        = 32'h0;
      b        = 32'h3;
      shamt    = 5'd10;
      in_valid = 1'b1;
      out_ready = 1'b1; // out_ready during SHIFT must be ignored
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL midshift_busy: busy=%b out_valid=%b need 1 0", busy, out_valid);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0 ||
          illegal !== 1'b0) begin
         errors++;
         $display("FAIL midshift_reset: out_valid=%b busy=%b in_ready=%b result=%h illegal=%b need 0 0 1 0 0",
                  out_valid, busy, in_ready, result, illegal);
      end
      out_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      issue_op(4'b0010, 32'd7, 32'd9, 5'd0, lat);
      checks++;
      if (lat != 1 || result !== 32'd16 || zero !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_add: lat=%0d result=%h zero=%b need 1 00000010 0",
                  lat, result, zero);
      end
      release_op();
   endtask

   task automatic test_back_to_back();
      int lat;
      issue_op(4'b0001, 32'h00F0, 32'h0F00, 5'd0, lat);
      release_op();
      issue_op(4'b1001, 32'h0, 32'h80000000, 5'd3, lat);
      checks++;
      if (lat != 4 || result !== 32'h10000000) begin
         errors++;
         $display("FAIL b2b_second: lat=%0d result=%h need 4 10000000", lat, result);
      end
      release_op();
   endtask

   task automatic test_random();
      logic [3:0]  legal [9];
      logic [3:0]  c;
      logic [31:0] av;
      logic [31:0] bv;
      logic [4:0]  s;
      logic [31:0] exp_r;
      int          lat;
      legal = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100, 4'b1000, 4'b1001, 4'b1010};
      for (int i = 0; i < 40; i++) begin
         c  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal[$urandom_range(0, 8)];
         av = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
         bv = ($urandom_range(0, 4) == 0) ? av : $urandom;
         s  = 5'($urandom);
         exp_r = ref_result(c, av, bv, s);
         issue_op(c, av, bv, s, lat);
         checks++;
         if (lat != ref_latency(c, s) || result !== exp_r || zero !== (exp_r == 0) ||
             illegal !== ref_illegal(c)) begin
            errors++;
            $display("FAIL rand%0d ctrl=%b a=%h b=%h s=%0d: lat=%0d result=%h zero=%b illegal=%b need %0d %h %b %b",
                     i, c, av, bv, s, lat, result, zero, illegal, ref_latency(c, s), exp_r,
                     exp_r == 0, ref_illegal(c));
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
         release_op();
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      alu_ctrl  = 4'b0;
      a         = 32'd0;
      b         = 32'd0;
      shamt     = 5'd0;
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_shift();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_iter_exec.md
Name: alu_iter_exec

Overview:
- EX-stage execution unit of the pipeline CPU. It consumes the 4-bit ALU control code produced by ALU control decode, together with the two operands and the shift amount.
- Logic/arithmetic ops complete in one cycle. Shifts (sll/srl/sra) run iteratively, one bit per cycle.
- A valid/ready handshake lets the hazard unit stall IF/ID/EX while a shift is in progress.
- Produces result, zero flag and illegal-op flag for the EX/MEM register.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation presented this cycle.
- in_ready  output  1  unit can accept an operation.
- alu_ctrl  input  4  ALU control code.
- a  input  WIDTH  operand A (rs).
- b  input  WIDTH  operand B (rt or sign-extended immediate); this is the shift source.
- shamt  input  SHAMT_W  shift amount.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  registered result.
- zero  output  1  result equals 0.
- illegal  output  1  alu_ctrl was not a legal code.
- busy  output  1  unit is in SHIFT or DONE; drives the pipeline stall.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: state=IDLE; in_ready=1; out_valid=0; busy=0; result=0; zero=0; illegal=0.
- Control codes:
  - 0010 add; 0110 sub; 0000 and; 0001 or.
  - 0111 slt: signed compare, result 1 or 0.
  - 1100 nor.
  - 1000 sll; 1001 srl; 1010 sra (sign fill).
  - Any other code, including X or Z, is illegal.
- Arithmetic: add/sub wrap modulo 2^WIDTH. No overflow flag. slt uses a signed comparison, not the sign of the subtraction.
- FSM states: IDLE, SHIFT, DONE. in_ready=1 only in IDLE; busy = (state != IDLE).
- Accept occurs when in_valid && in_ready in IDLE:
  - Non-shift legal op: result is computed combinationally and registered. Next state DONE, so out_valid rises 1 cycle after accept.
  - Illegal op: result=0, illegal=1, next state DONE.
  - Shift with shamt==0: result=b, next state DONE (latency 1).
  - Shift with shamt>0: load shift register with b and counter with shamt, go to SHIFT.
- SHIFT state:
  - Each cycle, shift one bit in the selected direction (sra replicates the MSB) and decrement the counter.
  - When the counter reaches 1 on an edge, that edge performs the final shift and enters DONE.
  - out_valid is asserted shamt+1 cycles after accept.
  - in_valid is ignored in SHIFT.
- DONE state:
  - out_valid=1. result, zero and illegal are held stable until out_ready.
  - On out_ready, go to IDLE and clear out_valid and illegal next cycle. result holds its last value.
  - No accept is possible in the same cycle as out_ready, so back-to-back ops have a minimum spacing of 2 cycles.
- zero is registered alongside result: zero = (next result == 0).
- Inputs are sampled only at accept. Changes to a, b, shamt or alu_ctrl during SHIFT or DONE have no effect.
- Reset asserted mid-SHIFT or mid-DONE: the operation is dropped and all outputs return to reset values immediately (asynchronous).
- out_ready asserted in IDLE or SHIFT is ignored.

Decomposition:
- Shared include (alu_ctrl_defs.vh), also used by ALU control decode:
  - Localparams for the 9 control codes.
  - Localparams for FSM state encodings.
- One sub-module, alu_core_comb: purely combinational single-cycle ops (add, sub, and, or, slt, nor) plus the illegal-code detect.
- The shift datapath and FSM stay in alu_iter_exec.

Test Plan:
- Add and sub:
  - add a=0x00000005, b=0x00000003 -> out_valid 1 cycle after accept, result=0x00000008, zero=0.
  - sub a=b=0x1234 -> result=0, zero=1.
- slt signed: a=0xFFFFFFFF, b=0x00000001 -> result=1. Swapped operands -> result=0.
- sll and sra:
  - sll b=0x00000001, shamt=31 -> busy high for 32 cycles, result=0x80000000, out_valid at accept+32.
  - sra b=0x80000000, shamt=4 -> result=0xF8000000.
- Illegal code and shamt=0:
  - alu_ctrl=0011 -> result=0, illegal=1 after 1 cycle.
  - srl with shamt=0, b=0xA5A5A5A5 -> result=0xA5A5A5A5 after 1 cycle.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result, zero and out_valid stable, in_ready=0, new in_valid ignored. Release -> IDLE next cycle.
- Reset mid-shift: reset asserted at cycle 3 of a shamt=10 sll -> out_valid=0, busy=0, in_ready=1 immediately. After deassert, a new add completes normally.
